// File: rtl/shift_unit_pkg.sv
// rtl/shift_unit_pkg.sv - op and state encodings shared by the iterative shifter
package shift_unit_pkg;

    typedef enum logic [1:0] {
        OP_SLL = 2'b00,
        OP_SRL = 2'b01,
        OP_SRA = 2'b10,
        OP_ROL = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_e;

    // Cycles from accepting start to the done pulse for a given amount.
    function automatic int shift_latency(input int shamt, input int step);
        return (shamt + step - 1) / step + 2;
    endfunction

endpackage

// File: rtl/iter_shift_unit_if.sv
// rtl/iter_shift_unit_if.sv - start/busy/done request bus of the iterative shifter
interface iter_shift_unit_if
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             start;
    shift_op_e        op;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] operand;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             result_zero;

    modport master (
        output start, op, shamt, operand,
        input  busy, done, result, result_zero
    );

    modport slave (
        input  start, op, shamt, operand,
        output busy, done, result, result_zero
    );

endinterface

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift by 0..STEP positions; rotate only with SHIFT_UNIT_ROTATE_EN
module shift_step
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic [WIDTH-1:0]           data,
    input  logic [$clog2(STEP+1)-1:0]  amt,
    input  shift_op_e                  op,
    input  logic                       sign,
    output logic [WIDTH-1:0]           shifted
);

    logic [WIDTH-1:0] fill_mask;

    always_comb begin
        // Bits vacated by a right shift, set to the sign for SRA.
        fill_mask = ~({WIDTH{1'b1}} >> amt);
        shifted   = data;
        case (op)
            OP_SLL: shifted = data << amt;
            OP_SRL: shifted = data >> amt;
            OP_SRA: shifted = (data >> amt) | (sign ? fill_mask : '0);
`ifdef SHIFT_UNIT_ROTATE_EN
            OP_ROL: shifted = (data << amt) | (data >> (WIDTH - int'(amt)));
`else
            OP_ROL: shifted = data << amt;
`endif
            default: shifted = data;
        endcase
    end

endmodule

// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - multi-cycle SLL/SRL/SRA shifter, ROL when SHIFT_UNIT_ROTATE_EN is defined
module iter_shift_unit
    import shift_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    iter_shift_unit_if.slave bus
);

    localparam int SHW = $clog2(WIDTH);
    localparam int AW  = $clog2(STEP + 1);
    localparam logic [SHW:0] STEP_V = (SHW + 1)'(STEP);

    state_e           state;
    logic [SHW-1:0]   count;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] stepped;
    shift_op_e        op_q;
    logic             sign_q;
    logic [AW-1:0]    step_amt;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] result_q;
    logic             result_zero_q;

    // Distance moved this cycle is min(STEP, count), so count never underflows.
    always_comb begin
        step_amt = AW'(count);
        if ({1'b0, count} >= STEP_V)
            step_amt = AW'(STEP_V);
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .data    (work),
        .amt     (step_amt),
        .op      (op_q),
        .sign    (sign_q),
        .shifted (stepped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            count         <= '0;
            work          <= '0;
            op_q          <= OP_SLL;
            sign_q        <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            result_q      <= '0;
            result_zero_q <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        work   <= bus.operand;
                        op_q   <= bus.op;
                        sign_q <= bus.operand[WIDTH-1];
                        count  <= bus.shamt;
                        busy_q <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (count != '0) begin
                        work  <= stepped;
                        count <= count - SHW'(step_amt);
                    end else begin
                        result_q      <= work;
                        result_zero_q <= (work == '0);
                        done_q        <= 1'b1;
                        state         <= DONE;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped; a new request needs IDLE.
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.result      = result_q;
    assign bus.result_zero = result_zero_q;

endmodule
